// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU time-share arbiter.
package alu_arb_pkg;

   localparam int          NUM_REQ    = 2;
   localparam int unsigned NOP_OP_DEF = 28;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way picker producing a one-hot grant.
// ALU_ARB_FIXED_PRI_EN selects fixed priority (requester 0 wins) instead of round-robin.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant
);

`ifdef ALU_ARB_FIXED_PRI_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant;

   always_comb begin
      grant = 2'b00;
      if (valid[0])
         grant = 2'b01;
      else if (valid[1])
         grant = 2'b10;
   end
`else
   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         // on conflict the requester that was not granted last wins
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end
`endif

endmodule

// File: rtl/alu_share_arb.sv
// Time-shares one combinational ALU between two requesters: accept, one EXEC cycle, registered response.
// Build option ALU_ARB_FIXED_PRI_EN: fixed priority for requester 0, no last_grant register.
module alu_share_arb
   import alu_arb_pkg::*;
#(
   parameter int          DATA_W = 16,
   parameter int          OP_W   = 5,
   parameter int unsigned NOP_OP = NOP_OP_DEF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]     req_a,
   input  logic [NUM_REQ*DATA_W-1:0]     req_b,
   input  logic [NUM_REQ*OP_W-1:0]       req_op,
   input  logic [NUM_REQ-1:0]            req_sign,
   output logic [DATA_W-1:0]             alu_a,
   output logic [DATA_W-1:0]             alu_b,
   output logic [OP_W-1:0]               alu_op,
   output logic                          alu_sign,
   input  logic [DATA_W-1:0]             alu_out,
   input  logic                          alu_ofl,
   input  logic                          alu_zero,
   output logic [NUM_REQ-1:0]            rsp_valid,
   input  logic [NUM_REQ-1:0]            rsp_ready,
   output logic [DATA_W-1:0]             rsp_out,
   output logic                          rsp_ofl,
   output logic                          rsp_zero
);

   localparam logic [OP_W-1:0] NOP_CODE = OP_W'(NOP_OP);

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic              sign_q, sign_d;
   logic [DATA_W-1:0] res_out_q, res_out_d;
   logic              res_ofl_q, res_ofl_d;
   logic              res_zero_q, res_zero_d;
   logic              last_grant;
   logic [1:0]        grant;
   logic              accept_en;
   logic              sel;

`ifdef ALU_ARB_FIXED_PRI_EN
   assign last_grant = 1'b1;
`else
   logic last_grant_q, last_grant_d;
   assign last_grant = last_grant_q;

   always_comb begin
      last_grant_d = last_grant_q;
      if (accept_en && (|req_valid))
         last_grant_d = sel;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         last_grant_q <= 1'b1;
      else
         last_grant_q <= last_grant_d;
   end
`endif

   rr_arb2 u_arb (
      .valid      (req_valid),
      .last_grant (last_grant),
      .grant      (grant)
   );

   assign sel = grant[1];

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      sign_d     = sign_q;
      res_out_d  = res_out_q;
      res_ofl_d  = res_ofl_q;
      res_zero_d = res_zero_q;
      req_ready  = '0;
      accept_en  = 1'b0;

      case (state_q)
         IDLE: accept_en = 1'b1;
         EXEC: begin
            res_out_d  = alu_out;
            res_ofl_d  = alu_ofl;
            res_zero_d = alu_zero;
            state_d    = RESP;
         end
         RESP: begin
            // a completing handshake frees the slot in the same cycle
            if (rsp_ready[owner_q]) begin
               state_d   = IDLE;
               accept_en = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (accept_en && (|req_valid)) begin
         req_ready = grant;
         owner_d   = sel;
         a_d       = sel ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
         b_d       = sel ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
         op_d      = sel ? req_op[2*OP_W-1:OP_W]    : req_op[OP_W-1:0];
         sign_d    = sel ? req_sign[1]              : req_sign[0];
         state_d   = EXEC;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         sign_q     <= 1'b0;
         res_out_q  <= '0;
         res_ofl_q  <= 1'b0;
         res_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         sign_q     <= sign_d;
         res_out_q  <= res_out_d;
         res_ofl_q  <= res_ofl_d;
         res_zero_q <= res_zero_d;
      end
   end

   // operands stay parked on the latches so the ALU inputs only move on a new op
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_sign  = sign_q;
   assign alu_op    = (state_q == EXEC) ? op_q : NOP_CODE;
   assign rsp_valid = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_out   = res_out_q;
   assign rsp_ofl   = res_ofl_q;
   assign rsp_zero  = res_zero_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: transaction-level reference checked every cycle plus directed literal checks.
module tb_alu_share_arb;

   localparam int DW  = 16;
   localparam int OW  = 5;
   localparam int NOP = 28;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      req_valid, req_ready, req_sign, rsp_valid, rsp_ready;
   logic [2*DW-1:0] req_a, req_b;
   logic [2*OW-1:0] req_op;
   logic [DW-1:0]   alu_a, alu_b, alu_out, rsp_out;
   logic [OW-1:0]   alu_op;
   logic            alu_sign, alu_ofl, alu_zero, rsp_ofl, rsp_zero;

   always #5 clk = ~clk;

   alu_share_arb dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_sign(req_sign),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_sign(alu_sign),
      .alu_out(alu_out), .alu_ofl(alu_ofl), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_out(rsp_out), .rsp_ofl(rsp_ofl), .rsp_zero(rsp_zero)
   );

   // Stand-in ALU: 0 ADD, 1 SUB (b-a), 2 OR, others XOR; returns {ofl, zero, out}
   function automatic logic [17:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                         input logic [4:0] op, input logic s);
      logic [16:0] w;
      logic [15:0] o;
      logic        f;
      case (op)
         5'd0: begin
            w = {1'b0, a} + {1'b0, b};
            o = w[15:0];
            f = s ? ((a[15] == b[15]) && (o[15] != a[15])) : w[16];
         end
         5'd1: begin
            o = b - a;
            f = s ? ((b[15] != a[15]) && (o[15] != b[15])) : (a > b);
         end
         5'd2:    begin o = a | b; f = 1'b0; end
         default: begin o = a ^ b; f = 1'b0; end
      endcase
      return {f, (o == 16'h0), o};
   endfunction

   assign {alu_ofl, alu_zero, alu_out} = alu_f(alu_a, alu_b, alu_op, alu_sign);

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit armed  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h cyc=%0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [1:0] pick(input logic [1:0] v, input logic last);
      if (v == 2'b01) return 2'b01;
      if (v == 2'b10) return 2'b10;
      if (v == 2'b00) return 2'b00;
`ifdef ALU_ARB_FIXED_PRI_EN
      return 2'b01;
`else
      return (last == 1'b0) ? 2'b10 : 2'b01;
`endif
   endfunction

   typedef struct {
      int          who;
      int          cyc;
      logic [15:0] out;
      logic        ofl;
      logic        zero;
   } ev_t;
   ev_t acc_log[$];
   ev_t rsp_log[$];

   // Reference: at most one op in flight; age 1 = ALU cycle, age 2 = response pending.
   bit          m_busy = 1'b0;
   int          m_age  = 0;
   logic        m_own  = 1'b0;
   logic        m_last = 1'b1;
   logic [15:0] m_a = '0, m_b = '0;
   logic [4:0]  m_op = '0;
   logic        m_sign = 1'b0;

   always @(negedge clk) begin
      logic [1:0]  exp_rv, exp_rr, g;
      logic [17:0] r;
      bit          can;
      ev_t         e;
      cyc++;
      if (armed) begin
         exp_rv = (m_busy && m_age == 2) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
         can    = !m_busy || (m_age == 2 && rsp_ready[m_own]);
         g      = pick(req_valid, m_last);
         exp_rr = can ? g : 2'b00;
         chk("req_ready", 32'(req_ready), 32'(exp_rr));
         chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
         if (m_busy && m_age == 2) begin
            r = alu_f(m_a, m_b, m_op, m_sign);
            chk("rsp_out",  32'(rsp_out),  32'(r[15:0]));
            chk("rsp_ofl",  32'(rsp_ofl),  32'(r[17]));
            chk("rsp_zero", 32'(rsp_zero), 32'(r[16]));
         end
         if (m_busy && m_age == 1) begin
            chk("alu_op_exec", 32'(alu_op), 32'(m_op));
            chk("alu_a_exec",  32'(alu_a),  32'(m_a));
            chk("alu_b_exec",  32'(alu_b),  32'(m_b));
            chk("alu_sign",    32'(alu_sign), 32'(m_sign));
         end else begin
            chk("alu_op_nop", 32'(alu_op), NOP);
         end
         if (|(req_ready & req_valid)) begin
            e.who = (req_ready[1] & req_valid[1]) ? 1 : 0;
            e.cyc = cyc; e.out = '0; e.ofl = 1'b0; e.zero = 1'b0;
            acc_log.push_back(e);
         end
         if (|(rsp_valid & rsp_ready)) begin
            e.who = (rsp_valid[1] & rsp_ready[1]) ? 1 : 0;
            e.cyc = cyc; e.out = rsp_out; e.ofl = rsp_ofl; e.zero = rsp_zero;
            rsp_log.push_back(e);
         end
         if (!rst_n) begin
            m_busy = 1'b0; m_age = 0; m_own = 1'b0; m_last = 1'b1;
            m_a = '0; m_b = '0; m_op = '0; m_sign = 1'b0;
         end else begin
            if (m_busy && m_age == 1)
               m_age = 2;
            else if (m_busy && m_age == 2 && rsp_ready[m_own])
               m_busy = 1'b0;
            if (can && (|req_valid)) begin
               m_busy = 1'b1; m_age = 1; m_own = g[1]; m_last = g[1];
               m_a    = g[1] ? req_a[31:16] : req_a[15:0];
               m_b    = g[1] ? req_b[31:16] : req_b[15:0];
               m_op   = g[1] ? req_op[9:5]  : req_op[4:0];
               m_sign = g[1] ? req_sign[1]  : req_sign[0];
            end
         end
      end
   end

   logic [15:0] ta [0:8];
   logic [15:0] tb [0:8];
   logic [4:0]  top[0:8];
   logic        ts [0:8];

   task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic [4:0] op, input logic s);
      req_a[i*DW +: DW]  = a;
      req_b[i*DW +: DW]  = b;
      req_op[i*OW +: OW] = op;
      req_sign[i]        = s;
   endtask

   task automatic load0(input int k);
      set_req(0, ta[k], tb[k], top[k], ts[k]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // req0 streams n0 table ops from base; req1 (fields preset) competes for one op when with1
   task automatic run_ops(input int base, input int n0, input bit with1);
      int         k0;
      logic [1:0] acc;
      bit         done;
      k0 = 0;
      if (n0 > 0) begin load0(base); req_valid[0] = 1'b1; end
      if (with1) req_valid[1] = 1'b1;
      done = (req_valid == 2'b00);
      for (int t = 0; t < 100 && !done; t++) begin
         @(negedge clk);
         acc = req_ready & req_valid;
         @(posedge clk); #1;
         if (acc[0]) begin
            k0++;
            if (k0 < n0) load0(base + k0);
            else req_valid[0] = 1'b0;
         end
         if (acc[1]) req_valid[1] = 1'b0;
         done = (req_valid == 2'b00);
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL run_ops_timeout got=pending want=accepted cyc=%0d", cyc);
         req_valid = 2'b00;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=running want=finished cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      int a0, r0;
      ta[0] = 16'd3;      tb[0] = 16'd4;      top[0] = 5'd0; ts[0] = 1'b0;
      ta[1] = 16'd2;      tb[1] = 16'd9;      top[1] = 5'd1; ts[1] = 1'b0;
      ta[2] = 16'd1;      tb[2] = 16'd2;      top[2] = 5'd0; ts[2] = 1'b0;
      ta[3] = 16'hFFFF;   tb[3] = 16'd1;      top[3] = 5'd0; ts[3] = 1'b0;
      ta[4] = 16'h7FFF;   tb[4] = 16'd1;      top[4] = 5'd0; ts[4] = 1'b1;
      ta[5] = 16'h0100;   tb[5] = 16'h0200;   top[5] = 5'd0; ts[5] = 1'b0;
      ta[6] = 16'd1;      tb[6] = 16'd1;      top[6] = 5'd0; ts[6] = 1'b0;
      ta[7] = 16'd2;      tb[7] = 16'd2;      top[7] = 5'd0; ts[7] = 1'b0;
      ta[8] = 16'd3;      tb[8] = 16'd3;      top[8] = 5'd0; ts[8] = 1'b0;

      rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
      req_a = '0; req_b = '0; req_op = '0; req_sign = '0;
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1; armed = 1'b1;

      // reset state
      @(negedge clk);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_out",   32'(rsp_out), 0);
      chk("rst_rsp_flags", 32'({rsp_ofl, rsp_zero}), 0);
      chk("rst_alu_op",    32'(alu_op), NOP);
      chk("rst_alu_ab",    32'({alu_a, alu_b}), 0);
      chk("rst_alu_sign",  32'(alu_sign), 0);
      @(posedge clk); #1;

      // single ADD 3+4, latency accept -> response is two cycles
      rsp_ready = 2'b11;
      a0 = acc_log.size(); r0 = rsp_log.size();
      run_ops(0, 1, 1'b0);
      idle(4);
      chk("t1_rsp_count", 32'(rsp_log.size() - r0), 1);
      if (rsp_log.size() > r0 && acc_log.size() > a0) begin
         chk("t1_out",     32'(rsp_log[r0].out), 7);
         chk("t1_ofl",     32'(rsp_log[r0].ofl), 0);
         chk("t1_who",     32'(rsp_log[r0].who), 0);
         chk("t1_latency", 32'(rsp_log[r0].cyc - acc_log[a0].cyc), 2);
      end

      // both valid out of reset, twice: order must alternate 0,1,0,1
      rst_n = 1'b0; idle(1); rst_n = 1'b1;
      a0 = acc_log.size(); r0 = rsp_log.size();
      set_req(1, 16'h00F0, 16'h000F, 5'd2, 1'b0);
      run_ops(1, 1, 1'b1);
      set_req(1, 16'h00F0, 16'h000F, 5'd2, 1'b0);
      run_ops(1, 1, 1'b1);
      idle(4);
      chk("t2_acc_count", 32'(acc_log.size() - a0), 4);
      chk("t2_rsp_count", 32'(rsp_log.size() - r0), 4);
      if (acc_log.size() >= a0 + 4 && rsp_log.size() >= r0 + 4) begin
         chk("t2_order", 32'({acc_log[a0].who[0], acc_log[a0+1].who[0],
                               acc_log[a0+2].who[0], acc_log[a0+3].who[0]}), 32'b0101);
         chk("t2_out0", 32'(rsp_log[r0].out),   7);
         chk("t2_out1", 32'(rsp_log[r0+1].out), 16'h00FF);
         chk("t2_out2", 32'(rsp_log[r0+2].out), 7);
         chk("t2_out3", 32'(rsp_log[r0+3].out), 16'h00FF);
      end

      // contention while req0 streams three ops
      a0 = acc_log.size();
      set_req(1, 16'h0010, 16'h0001, 5'd2, 1'b0);
      run_ops(6, 3, 1'b1);
      idle(4);
      chk("t3_acc_count", 32'(acc_log.size() - a0), 4);
      if (acc_log.size() >= a0 + 4)
`ifdef ALU_ARB_FIXED_PRI_EN
         chk("t3_order", 32'({acc_log[a0].who[0], acc_log[a0+1].who[0],
                               acc_log[a0+2].who[0], acc_log[a0+3].who[0]}), 32'b0001);
`else
         chk("t3_order", 32'({acc_log[a0].who[0], acc_log[a0+1].who[0],
                               acc_log[a0+2].who[0], acc_log[a0+3].who[0]}), 32'b0100);
`endif

      // back-to-back stream of four ADDs: one accept every two cycles
      a0 = acc_log.size(); r0 = rsp_log.size();
      run_ops(2, 4, 1'b0);
      idle(4);
      chk("t4_rsp_count", 32'(rsp_log.size() - r0), 4);
      if (acc_log.size() >= a0 + 4 && rsp_log.size() >= r0 + 4) begin
         for (int k = 0; k < 3; k++)
            chk("t4_interval", 32'(acc_log[a0+k+1].cyc - acc_log[a0+k].cyc), 2);
         chk("t4_out0",  32'(rsp_log[r0].out), 3);
         chk("t4_out1",  32'({rsp_log[r0+1].ofl, rsp_log[r0+1].zero, rsp_log[r0+1].out}), 32'h30000);
         chk("t4_out2",  32'({rsp_log[r0+2].ofl, rsp_log[r0+2].out}), 32'h18000);
         chk("t4_out3",  32'(rsp_log[r0+3].out), 16'h0300);
      end

      // req1 signed overflow with stalled response; non-owner ready is ignored
      rsp_ready = 2'b01;
      r0 = rsp_log.size();
      set_req(1, 16'h7FFF, 16'h0001, 5'd0, 1'b1);
      run_ops(0, 0, 1'b1);
      load0(0); req_valid[0] = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t5_stall_valid", 32'(rsp_valid), 32'b10);
         chk("t5_stall_out",   32'(rsp_out), 16'h8000);
         chk("t5_stall_ofl",   32'(rsp_ofl), 1);
         chk("t5_stall_ready", 32'(req_ready), 0);
      end
      @(posedge clk); #1;
      rsp_ready = 2'b10;
      @(negedge clk);
      chk("t5_b2b_ready", 32'(req_ready), 32'b01);
      chk("t5_b2b_valid", 32'(rsp_valid), 32'b10);
      @(posedge clk); #1;
      req_valid = 2'b00; rsp_ready = 2'b11;
      idle(4);
      chk("t5_rsp_count", 32'(rsp_log.size() - r0), 2);
      if (rsp_log.size() >= r0 + 2) begin
         chk("t5_first",  32'({rsp_log[r0].who[0], rsp_log[r0].out}), 32'h18000);
         chk("t5_second", 32'({rsp_log[r0+1].who[0], rsp_log[r0+1].out}), 32'h00007);
      end

      // reset during EXEC drops the op
      set_req(0, 16'd5, 16'd5, 5'd1, 1'b0);
      req_valid = 2'b01;
      @(negedge clk);
      chk("t6_accept", 32'(req_ready), 32'b01);
      @(posedge clk); #1;
      req_valid = 2'b00; rst_n = 1'b0;
      r0 = rsp_log.size();
      @(negedge clk);
      chk("t6_exec_op", 32'(alu_op), 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_rsp_valid", 32'(rsp_valid), 0);
      chk("t6_alu_op",    32'(alu_op), NOP);
      chk("t6_alu_a",     32'(alu_a), 0);
      @(posedge clk); #1;
      idle(3);
      chk("t6_no_rsp", 32'(rsp_log.size() - r0), 0);
      req_valid = 2'b10;
      @(negedge clk);
      chk("t6_idle_accept", 32'(req_ready), 32'b10);
      @(posedge clk); #1;
      req_valid = 2'b00;
      idle(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
